// File: rtl/dmem_dump_pkg.sv
// Shared definitions for the data-memory dump engine: word type, width and FSM states.
package dmem_dump_pkg;

  localparam int WORD_W = 17;

  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    SEND  = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/dmem_dump.sv
// Data-memory dump engine: walks words 0..DEPTH-1 through a dedicated
// combinational read port and streams (address, word) over valid/ready.
// Optional feature macro: DMEM_DUMP_SKIP_ZERO_EN -- zero words below the
// terminal address are skipped instead of presented.
module dmem_dump
  import dmem_dump_pkg::*;
#(
  parameter int DEPTH = 128
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [WORD_W-1:0] mem_addr,
  input  logic [WORD_W-1:0] mem_rd,
  output logic              dout_valid,
  input  logic              dout_ready,
  output logic [WORD_W-1:0] dout_data,
  output logic [WORD_W-1:0] dout_addr,
  output logic              dout_last
);

  // Terminal address; the counter stops here and never wraps.
  localparam word_t LAST_ADDR = word_t'(DEPTH - 1);
  localparam word_t ONE       = word_t'(1);
  localparam word_t ZERO      = word_t'(0);

  state_t state_r, next_state_s;
  word_t  cnt_r,   cnt_s;
  word_t  data_r,  data_s;
  word_t  addr_r,  addr_s;
  logic   last_r,  last_s;
  logic   valid_r;
  logic   busy_r;
  logic   done_r;
  logic   accept_s;
  logic   at_end_s;
  logic   skip_s;

  // Next-state, counter and capture logic for the dump walk.
  always_comb begin
    next_state_s = state_r;
    cnt_s        = cnt_r;
    data_s       = data_r;
    addr_s       = addr_r;
    last_s       = last_r;
    accept_s     = valid_r && dout_ready;
    at_end_s     = (cnt_r == LAST_ADDR);
`ifdef DMEM_DUMP_SKIP_ZERO_EN
    skip_s       = (mem_rd == ZERO) && !at_end_s;
`else
    skip_s       = 1'b0;
`endif

    case (state_r)
      IDLE: begin
        if (start) begin
          cnt_s        = ZERO;
          next_state_s = FETCH;
        end else begin
          next_state_s = IDLE;
        end
      end
      FETCH: begin
        if (skip_s) begin
          // Zero word not presented: advance and fetch the next address.
          cnt_s        = cnt_r + ONE;
          next_state_s = FETCH;
        end else begin
          data_s       = mem_rd;
          addr_s       = cnt_r;
          last_s       = at_end_s;
          next_state_s = SEND;
        end
      end
      SEND: begin
        if (accept_s) begin
          if (last_r) begin
            next_state_s = DONE;
          end else begin
            cnt_s        = cnt_r + ONE;
            next_state_s = FETCH;
          end
        end else begin
          next_state_s = SEND;
        end
      end
      DONE: begin
        next_state_s = IDLE;
      end
      default: begin
        next_state_s = IDLE;
      end
    endcase
  end

  // State, counter and output registers; status flags are decoded from the next state
  // so that every output is a flop.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= IDLE;
      cnt_r   <= ZERO;
      data_r  <= ZERO;
      addr_r  <= ZERO;
      last_r  <= 1'b0;
      valid_r <= 1'b0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= next_state_s;
      cnt_r   <= cnt_s;
      data_r  <= data_s;
      addr_r  <= addr_s;
      last_r  <= last_s;
      valid_r <= (next_state_s == SEND);
      busy_r  <= (next_state_s != IDLE);
      done_r  <= (next_state_s == DONE);
    end
  end

  assign mem_addr   = cnt_r;
  assign busy       = busy_r;
  assign done       = done_r;
  assign dout_valid = valid_r;
  assign dout_data  = data_r;
  assign dout_addr  = addr_r;
  assign dout_last  = last_r;

endmodule

// File: tb/tb_dmem_dump.sv
// Directed self-checking bench for dmem_dump with DEPTH=4.
module tb_dmem_dump;

  logic        clk;
  logic        reset;
  logic        start;
  logic        busy;
  logic        done;
  logic [16:0] mem_addr;
  logic [16:0] mem_rd;
  logic        dout_valid;
  logic        dout_ready;
  logic [16:0] dout_data;
  logic [16:0] dout_addr;
  logic        dout_last;

  logic [16:0] mem [0:3];

  int total_cnt;
  int pass_cnt;

  dmem_dump #(.DEPTH(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .busy       (busy),
    .done       (done),
    .mem_addr   (mem_addr),
    .mem_rd     (mem_rd),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .dout_data  (dout_data),
    .dout_addr  (dout_addr),
    .dout_last  (dout_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Combinational memory read port model.
  always_comb begin
    if (mem_addr < 17'd4) mem_rd = mem[mem_addr[1:0]];
    else                  mem_rd = 17'd0;
  end

  task automatic chk(input string tag, input logic [16:0] obs, input logic [16:0] exp);
    total_cnt++;
    assert (obs === exp) begin
      pass_cnt++;
    end else begin
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [16:0] expw(input int k);
    case (k)
      0:       return 17'h00005;
      1:       return 17'h00000;
      2:       return 17'h1FFFF;
      3:       return 17'h00007;
      default: return 17'h00000;
    endcase
  endfunction

  task automatic exp_fetch(input int a);
    chk("fetch_valid", {16'd0, dout_valid}, 17'd0);
    chk("fetch_busy",  {16'd0, busy},       17'd1);
    chk("fetch_done",  {16'd0, done},       17'd0);
    chk("fetch_addr",  mem_addr,            17'(a));
  endtask

  task automatic exp_send(input int k, input logic [16:0] d, input logic lst);
    chk("send_valid", {16'd0, dout_valid}, 17'd1);
    chk("send_busy",  {16'd0, busy},       17'd1);
    chk("send_done",  {16'd0, done},       17'd0);
    chk("send_addr",  dout_addr,           17'(k));
    chk("send_data",  dout_data,           d);
    chk("send_last",  {16'd0, dout_last},  {16'd0, lst});
  endtask

  task automatic exp_done();
    chk("done_pulse", {16'd0, done},       17'd1);
    chk("done_busy",  {16'd0, busy},       17'd1);
    chk("done_valid", {16'd0, dout_valid}, 17'd0);
  endtask

  task automatic exp_idle();
    chk("idle_done",  {16'd0, done},       17'd0);
    chk("idle_busy",  {16'd0, busy},       17'd0);
    chk("idle_valid", {16'd0, dout_valid}, 17'd0);
  endtask

  task automatic exp_reset_vals(input string tag);
    chk({tag, "_busy"},  {16'd0, busy},       17'd0);
    chk({tag, "_done"},  {16'd0, done},       17'd0);
    chk({tag, "_valid"}, {16'd0, dout_valid}, 17'd0);
    chk({tag, "_last"},  {16'd0, dout_last},  17'd0);
    chk({tag, "_data"},  dout_data,           17'd0);
    chk({tag, "_daddr"}, dout_addr,           17'd0);
    chk({tag, "_maddr"}, mem_addr,            17'd0);
  endtask

  // Positioned in FETCH of word 'first' with ready high: run to DONE and back to IDLE.
  task automatic drain(input int first);
    for (int k = first; k < 4; k++) begin
      step();
      exp_send(k, expw(k), (k == 3));
      step();
      if (k < 3) exp_fetch(k + 1);
      else       exp_done();
    end
    step();
    exp_idle();
  endtask

  initial begin
    total_cnt  = 0;
    pass_cnt   = 0;
    reset      = 1'b0;
    start      = 1'b0;
    dout_ready = 1'b0;
    mem[0] = 17'h00005;
    mem[1] = 17'h00000;
    mem[2] = 17'h1FFFF;
    mem[3] = 17'h00007;

    #1 reset = 1'b1;
    #1;
    exp_reset_vals("reset");
    step();
    step();
    reset = 1'b0;
    step();
    exp_reset_vals("post_reset");

`ifdef DMEM_DUMP_SKIP_ZERO_EN
    // Zero at address 1 is skipped.
    dout_ready = 1'b1;
    start = 1'b1;
    step();
    start = 1'b0;
    exp_fetch(0);
    step();
    exp_send(0, 17'h00005, 1'b0);
    step();
    exp_fetch(1);
    step();
    exp_fetch(2);
    step();
    exp_send(2, 17'h1FFFF, 1'b0);
    step();
    exp_fetch(3);
    step();
    exp_send(3, 17'h00007, 1'b1);
    step();
    exp_done();
    step();
    exp_idle();

    // All-zero memory: only the terminal word is emitted.
    mem[0] = 17'h00000;
    mem[2] = 17'h00000;
    mem[3] = 17'h00000;
    start = 1'b1;
    step();
    start = 1'b0;
    exp_fetch(0);
    step();
    exp_fetch(1);
    step();
    exp_fetch(2);
    step();
    exp_fetch(3);
    step();
    exp_send(3, 17'h00000, 1'b1);
    step();
    exp_done();
    step();
    exp_idle();
`else
    // Full dump with ready held high: words on cycles 2/4/6/8, done on 9.
    dout_ready = 1'b1;
    start = 1'b1;
    step();
    start = 1'b0;
    exp_fetch(0);
    drain(0);

    // Backpressure on word 1 for three cycles.
    start = 1'b1;
    step();
    start = 1'b0;
    exp_fetch(0);
    step();
    exp_send(0, 17'h00005, 1'b0);
    step();
    exp_fetch(1);
    dout_ready = 1'b0;
    step();
    exp_send(1, 17'h00000, 1'b0);
    repeat (3) begin
      step();
      exp_send(1, 17'h00000, 1'b0);
    end
    dout_ready = 1'b1;
    step();
    exp_fetch(2);
    drain(2);

    // start in SEND and in DONE ignored; start right after done restarts.
    start = 1'b1;
    step();
    start = 1'b0;
    exp_fetch(0);
    step();
    exp_send(0, 17'h00005, 1'b0);
    start = 1'b1;
    step();
    start = 1'b0;
    exp_fetch(1);
    step();
    exp_send(1, 17'h00000, 1'b0);
    step();
    exp_fetch(2);
    step();
    exp_send(2, 17'h1FFFF, 1'b0);
    step();
    exp_fetch(3);
    step();
    exp_send(3, 17'h00007, 1'b1);
    step();
    exp_done();
    start = 1'b1;
    step();
    exp_idle();
    step();
    start = 1'b0;
    exp_fetch(0);
    step();
    exp_send(0, 17'h00005, 1'b0);

    // Reset during SEND of address 2 aborts immediately.
    step();
    exp_fetch(1);
    step();
    exp_send(1, 17'h00000, 1'b0);
    step();
    exp_fetch(2);
    step();
    exp_send(2, 17'h1FFFF, 1'b0);
    reset = 1'b1;
    #1;
    exp_reset_vals("mid_reset");
    step();
    step();
    reset = 1'b0;
    step();
    exp_reset_vals("after_abort");
    step();
    exp_idle();
    start = 1'b1;
    step();
    start = 1'b0;
    exp_fetch(0);
    drain(0);
`endif

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/dmem_dump.md
# dmem_dump

Data-memory dump engine for the 17-bit MIPS system: the reader counterpart to the core's store path. On a start pulse it walks data-memory words 0..DEPTH-1 through a dedicated combinational read port and streams each word, tagged with its address, out over a valid/ready interface. It sits beside `DataMemory` as a second read port and feeds debug/host logic. It never writes memory.

## Interface
- `DEPTH`, 128: number of data-memory words dumped; must be ≥2 and ≤ 2^17.
- `WORD_W`, 17: data and address width; fixed by the core datapath.
- `clk` input 1: single clock, rising edge.
- `reset` input 1: asynchronous, active-high.
- `start` input 1: one-cycle request to begin a dump; sampled only in IDLE.
- `busy` output 1: high in FETCH, SEND and DONE.
- `done` output 1: one-cycle pulse when the dump completes.
- `mem_addr` output 17: word address, zero-extended, driven to memory read port.
- `mem_rd` input 17: combinational read data for `mem_addr`.
- `dout_valid` output 1: stream word available.
- `dout_ready` input 1: consumer accepts the word when high with `dout_valid`.
- `dout_data` output 17: memory word.
- `dout_addr` output 17: address of `dout_data`.
- `dout_last` output 1: high with the word from address DEPTH-1.

## Operation
- States: IDLE, FETCH, SEND, DONE.
- IDLE: `start`=1 → address counter cleared to 0, go to FETCH; otherwise stay.
- FETCH: `mem_addr` = counter; at clock edge capture `mem_rd` into `dout_data`, counter into `dout_addr`, set `dout_last` = (counter == DEPTH-1); go to SEND.
- SEND: `dout_valid`=1. On `dout_valid && dout_ready`: if `dout_last`, go to DONE; else increment counter and go to FETCH. While not accepted, `dout_data`/`dout_addr`/`dout_last` remain stable.
- DONE: `done`=1 for exactly one cycle, then IDLE.
- `start` outside IDLE is ignored; it is not queued.
- `dout_ready` outside SEND has no effect.
- Counter never wraps: DEPTH-1 is the terminal address.
- `mem_addr` holds its last value outside FETCH. Memory contents are sampled at the end of each FETCH cycle. Core stores after that edge are not reflected in the captured word.

## Timing
- Reset (async assert) → IDLE; `busy`, `done`, `dout_valid`, `dout_last` = 0; `dout_data`, `dout_addr`, `mem_addr`, counter = 0. Reset mid-dump aborts with no further output.
- `start` at edge N → FETCH in cycle N+1. First `dout_valid` appears in cycle N+2.
- Throughput: 2 cycles/word with `dout_ready` held high. A full dump takes 2·DEPTH+1 cycles from start to the `done` cycle, inclusive of DONE.
- `done` asserts the cycle after the last handshake. `busy` falls the cycle after `done`.
- All outputs are registered except `mem_addr`, which is the counter register itself.

## Configuration
- `DMEM_DUMP_SKIP_ZERO_EN`:
  - Defined: in FETCH, a captured word equal to 0 at an address below DEPTH-1 is not presented. The counter increments and FETCH repeats, one cycle per skipped word. The word at DEPTH-1 is always emitted, so `dout_last` is always seen.
  - Undefined: every word is emitted.

## Structure
- Shared package `dmem_dump_pkg`: state enum (IDLE, FETCH, SEND, DONE), `WORD_W`=17 constant, and the word typedef shared with the core datapath.
- No sub-module: the FSM, counter and output register are in one module.

## Test plan
- DEPTH=4, memory {5, 0, 0x1FFFF, 7}, `dout_ready`=1, `start` pulse → words (addr,data) (0,5), (1,0), (2,0x1FFFF), (3,7) on cycles 2/4/6/8 after start. `dout_last` is high only with addr 3. `done` pulses on cycle 9.
- Backpressure: `dout_ready`=0 for 3 cycles on word 1 → `dout_valid` held and data/addr stable for those cycles; the sequence then resumes unchanged.
- `start` asserted in SEND and in DONE → ignored; exactly one dump. A `start` in the cycle after `done` begins a new dump from address 0.
- `reset` asserted while SEND with addr 2 → all outputs 0 immediately. After release the block is idle; a subsequent `start` dumps from address 0.
- With `DMEM_DUMP_SKIP_ZERO_EN` and the memory above → only (0,5), (2,0x1FFFF), (3,7) are emitted. With memory all zero → only (3,0) is emitted, with `dout_last`=1.
